// File: rtl/regfile_sb.sv
// regfile_sb: parametrised integer register file with optional
// write-to-read bypass and a per-register pending scoreboard.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   rs1, rs2            read indices
//   readout1, readout2  combinational read data
//   enW, rd, in         write port (writeback)
//   alloc_en, alloc_rd  mark a register pending (long-latency issue)
//   busy1, busy2        pending status of rs1 / rs2
//   any_busy            OR of all pending bits
module regfile_sb #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int AW     = 5,
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] readout1,
  output logic [XLEN-1:0] readout2,
  input  logic            enW,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] in,
  input  logic            alloc_en,
  input  logic [AW-1:0]   alloc_rd,
  output logic            busy1,
  output logic            busy2,
  output logic            any_busy
);

  // x0 has no storage; indices 1..NREG-1 only.
  logic [XLEN-1:0] regs_q [1:NREG-1];
  logic [XLEN-1:0] regs_d [1:NREG-1];
  logic [NREG-1:1] pend_q;
  logic [NREG-1:1] pend_d;

  logic            wr_ok;
  logic            al_ok;
  logic            byp1;
  logic            byp2;
  logic [XLEN-1:0] raw1;
  logic [XLEN-1:0] raw2;
  logic            pb1;
  logic            pb2;

  assign wr_ok = enW && (rd != '0)
              && (int'(rd) < NREG);
  assign al_ok = alloc_en
              && (alloc_rd != '0)
              && (int'(alloc_rd) < NREG);

  // Stored-value lookup; out-of-range and
  // x0 fall through to zero.
  always_comb begin
    raw1 = '0;
    raw2 = '0;
    pb1  = 1'b0;
    pb2  = 1'b0;
    for (int i = 1; i < NREG; i++) begin
      if (rs1 == AW'(i)) begin
        raw1 = regs_q[i];
        pb1  = pend_q[i];
      end
      if (rs2 == AW'(i)) begin
        raw2 = regs_q[i];
        pb2  = pend_q[i];
      end
    end
  end

  assign byp1 = (BYPASS != 0) && wr_ok
             && (rs1 == rd);
  assign byp2 = (BYPASS != 0) && wr_ok
             && (rs2 == rd);

  // rst_n gates the forward path so outputs
  // read zero for as long as reset is held.
  always_comb begin
    readout1 = '0;
    readout2 = '0;
    if (rst_n) begin
      readout1 = byp1 ? in : raw1;
      readout2 = byp2 ? in : raw2;
    end
  end

  // A forwarded write satisfies the consumer
  // this cycle, so it no longer waits.
  assign busy1 = rst_n && !byp1 && pb1;
  assign busy2 = rst_n && !byp2 && pb2;

  assign any_busy = |pend_q;

  // Clear-then-set: an alloc in the same cycle
  // as the write belongs to a newer producer.
  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    for (int i = 1; i < NREG; i++) begin
      if (wr_ok && (rd == AW'(i))) begin
        regs_d[i] = in;
        pend_d[i] = 1'b0;
      end
      if (al_ok && (alloc_rd == AW'(i))) begin
        pend_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      pend_q <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
    end
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the fixed single-cycle integer register file.
- Generalised in data width and register count.
- Adds asynchronous reset of all registers, optional write-to-read bypass and a per-register pending scoreboard for multi-cycle producers (loads, mul/div).
- Sits between decode (read/allocate) and writeback (write) in the RV32 core; x0 stays hardwired zero.

Parameters:
XLEN, 32, data width of each register and of every data port
NREG, 32, number of architectural registers (2..32); index 0 is always the zero register
AW, 5, register index width; must satisfy 2**AW >= NREG
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return the stored value only

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
rs1  input  AW  read index, port 1
rs2  input  AW  read index, port 2
readout1  output  XLEN  read data, port 1 (combinational)
readout2  output  XLEN  read data, port 2 (combinational)
enW  input  1  write enable
rd  input  AW  write index
in  input  XLEN  write data
alloc_en  input  1  mark alloc_rd pending (long-latency producer issued)
alloc_rd  input  AW  register to mark pending
busy1  output  1  rs1 has an outstanding producer
busy2  output  1  rs2 has an outstanding producer
any_busy  output  1  OR of all pending bits

Behaviour:
- Reset (rst_n low, asynchronous, independent of clk):
  - All NREG registers clear to 0; all pending bits clear.
  - readout1/2 = 0, busy1/2 = 0, any_busy = 0 while held.
  - Release is synchronous to the next clk edge; ops in flight during reset are dropped.
- Write:
  - At posedge clk, if enW and rd != 0 and rd < NREG: reg[rd] <= in.
  - Writes to index 0 or index >= NREG are ignored.
- Read:
  - Purely combinational, zero latency.
  - readoutN = 0 if rsN == 0 or rsN >= NREG; otherwise reg[rsN].
- Bypass (BYPASS=1 only):
  - If enW and rd == rsN and rd != 0 and rd < NREG, readoutN = in in the same cycle, i.e. write-first.
  - With BYPASS=0 the new value is visible the cycle after the write.
- Scoreboard:
  - One pending bit per register; bit 0 is constant 0.
  - At posedge: a write (enW, valid rd) clears pending[rd]; alloc_en with valid alloc_rd sets pending[alloc_rd].
  - Alloc and write to the same register in the same cycle: set wins. The write commits and the register stays pending for the newer producer.
  - Alloc to index 0 or >= NREG is ignored.
- Busy outputs:
  - busyN = pending[rsN] for valid nonzero rsN, else 0.
  - With BYPASS=1, busyN is forced 0 when the same-cycle write targets rsN, since the data is forwarded.
  - any_busy = OR of pending[1..NREG-1]. It is registered-state derived, so no same-cycle bypass effect applies.
- Read ports have no side effects; rs1 == rs2 is legal and both ports return identical data.
- There is no ordering check: a write to a non-pending register is legal and still updates it.

Test Plan:
- Reset mid-operation: write 0xDEADBEEF to x5, alloc x7, assert rst_n low between clock edges -> readout1(rs1=5)=0 and any_busy=0 immediately, before the next edge.
- x0 and out-of-range: enW, rd=0, in=0xFFFFFFFF; then with NREG=24, write rd=30 -> rs1=0 reads 0, rs2=30 reads 0, no register changed.
- Bypass: BYPASS=1, enW, rd=9, in=0x12345678, rs1=rs2=9 in the same cycle -> readout1=readout2=0x12345678 that cycle. Repeat with BYPASS=0 -> old value that cycle, new value the next cycle.
- Scoreboard: alloc x18 -> next cycle busy1(rs1=18)=1 and any_busy=1. Write x18=0xA5 -> busy1 reads 0 in the write cycle (BYPASS=1); next cycle pending[18]=0 and any_busy=0.
- Simultaneous set/clear: alloc_rd=rd=20 with enW=1, in=0x55 in one cycle -> reg[20]=0x55 and busy1(rs1=20)=1 the next cycle.
- Width sweep: XLEN=64, NREG=32, write 0x8000_0000_0000_0001 to x31 -> readout2(rs2=31) returns the full 64-bit value.
